multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle main control FSM for the MIPS datapath; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction from OP, Zero and a memory-ready handshake.
//  Drives datapath mux selects, write enables and ALUOp; sits between the instruction register and datapath.
// PARAMETERS
//  ALUOP_WIDTH  3       width of ALUOp; ALUOP_* localparam codes are zero-extended to this width
//  ALUOP_ADD    3'b100  ALUOp for address/PC arithmetic and ADDI
//  ALUOP_SUB    3'b011  ALUOp for BEQ/BNE compare
//  ALUOP_OR     3'b101  ALUOp for ORI and LUI
//  ALUOP_AND    3'b110  ALUOp for ANDI
//  ALUOP_R      3'b111  ALUOp for R-type; ALU control decodes funct
//  MEM_TIMEOUT  15      max consecutive wait cycles on mem_ready before trap; must be >=1
// PORTS
//  clk         in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-high; forces state to FETCH
//  OP          in   6            opcode from instruction register
//  Zero        in   1            ALU zero flag, valid in BRANCH state
//  mem_ready   in   1            memory completes the current read or write this cycle
//  PCWrite     out  1            PC load enable (unconditional or resolved branch)
//  IorD        out  1            memory address select: 0=PC, 1=ALUOut
//  MemRead     out  1            memory read request
//  MemWrite    out  1            memory write request
//  IRWrite     out  1            instruction register load
//  MemtoReg    out  2            write-back data: 00=ALUOut, 01=MDR, 10=PC (link)
//  RegDst      out  2            destination: 00=rt, 01=rd, 10=$31
//  RegWrite    out  1            register file write enable
//  ALUSrcA     out  1            0=PC, 1=rs
//  ALUSrcB     out  2            00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//                                (ORI/ANDI zero-extend inside the datapath)
//  PCSource    out  2            00=ALU result, 01=ALUOut, 10=jump target
//  ALUOp       out  ALUOP_WIDTH  ALU operation class
//  illegal_op  out  1            sticky; set on unsupported opcode or memory timeout
// BEHAVIOUR
//  - State register updates on posedge clk. Outputs are combinational from state; PCWrite also uses Zero and mem_ready.
//  - While reset=1, state=FETCH, wait counter=0, illegal_op=0, and all outputs are forced to 0.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
//      Stays in FETCH until mem_ready=1. In that cycle IRWrite=1, PCWrite=1, then go to DECODE.
//  - DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state by OP:
//      0x00 -> EXE_R; 0x08/0x0d/0x0c/0x0f -> EXE_I; 0x23/0x2b -> MEMADR; 0x04/0x05 -> BRANCH;
//      0x02/0x03 -> JUMP (macro-dependent); any other opcode -> TRAP.
//  - EXE_R: ALUSrcA=1, ALUSrcB=00, ALUOp=R -> ALUWB.
//  - EXE_I: ALUSrcA=1, ALUSrcB=10; ALUOp ADD (ADDI), OR (ORI, LUI), AND (ANDI) -> ALUWB.
//  - ALUWB: RegWrite=1, MemtoReg=00, RegDst=01 if OP=0 else 00 -> FETCH.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next is MEMRD for LW, MEMWR for SW.
//  - MEMRD: MemRead=1, IorD=1; wait for mem_ready -> MEMWB. MEMWB: RegWrite=1, MemtoReg=01, RegDst=00 -> FETCH.
//  - MEMWR: MemWrite=1, IorD=1; wait for mem_ready -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01.
//      PCWrite = Zero for BEQ, ~Zero for BNE. Always go to FETCH (3 cycles total).
//  - TRAP: all outputs 0, illegal_op=1. Stays in TRAP until reset.
//  - Wait counter: clears on every state change. In FETCH/MEMRD/MEMWR it increments each cycle mem_ready=0.
//      When it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP.
//      mem_ready=1 in the same cycle that the count hits MEM_TIMEOUT counts as success; no trap.
//  - Latency: R/I-type 4 cycles, LW 5, SW 4, branch 3, jump 3 (zero-wait memory).
//  - Reset mid-instruction aborts it; no partial RegWrite/MemWrite after reset asserts.
// CONFIGURATION
//  MULTICYCLE_CTRL_JUMP_EN defined:
//    JUMP state: PCSource=10, PCWrite=1.
//    For JAL (0x03) also RegWrite=1, RegDst=10, MemtoReg=10 (PC+4 into $31). Then -> FETCH.
//  Not defined: no JUMP state; opcodes 0x02/0x03 go DECODE -> TRAP and set illegal_op.
// TESTING
//  ADDI (OP=0x08), mem_ready tied 1 -> FETCH,DECODE,EXE_I,ALUWB; ALUOp=100, RegWrite=1 only in cycle 4, RegDst=00.
//  LW (0x23), mem_ready low 3 cycles in MEMRD -> MemRead,IorD held 3 cycles; then MEMWB with MemtoReg=01.
//  BEQ Zero=1 -> PCWrite=1,PCSource=01 in BRANCH; BNE Zero=1 -> PCWrite=0; both return to FETCH.
//  OP=0x3f -> TRAP after DECODE, illegal_op=1 sticky; reset=1 clears it and returns to FETCH.
//  mem_ready=0 in FETCH for 15 cycles -> TRAP; repeat with mem_ready=1 on 15th cycle -> DECODE, no trap.
//  JAL with macro -> RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10; without macro -> TRAP.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back and drives datapath controls.
// Optional J/JAL support is enabled by defining MULTICYCLE_CTRL_JUMP_EN; otherwise those opcodes trap.
module multicycle_control #(
    parameter int ALUOP_WIDTH = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   Zero,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             MemtoReg,
    output logic [1:0]             RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   illegal_op
);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = ALUOP_WIDTH'(3'b100);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = ALUOP_WIDTH'(3'b011);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR  = ALUOP_WIDTH'(3'b101);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND = ALUOP_WIDTH'(3'b110);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_R   = ALUOP_WIDTH'(3'b111);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    // Last wait count before trapping: one more idle cycle here exhausts the budget.
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_TRAP
`ifdef MULTICYCLE_CTRL_JUMP_EN
        , S_JUMP
`endif
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic          waiting;
    logic          timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    assign waiting   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign timed_out = !mem_ready && (wait_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
                      else if (timed_out) state_next = S_TRAP;
            S_DECODE: begin
                case (OP)
                    6'h00:                      state_next = S_EXE_R;
                    6'h08, 6'h0d, 6'h0c, 6'h0f: state_next = S_EXE_I;
                    6'h23, 6'h2b:               state_next = S_MEMADR;
                    6'h04, 6'h05:               state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    6'h02, 6'h03:               state_next = S_JUMP;
`endif
                    default:                    state_next = S_TRAP;
                endcase
            end
            S_EXE_R, S_EXE_I: state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_MEMADR: state_next = (OP == 6'h2b) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
                      else if (timed_out) state_next = S_TRAP;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
                      else if (timed_out) state_next = S_TRAP;
            S_BRANCH: state_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP:   state_next = S_FETCH;
`endif
            default:  state_next = S_TRAP;
        endcase

        wait_next = wait_reg;
        if (state_next != state_reg)
            wait_next = '0;
        else if (waiting && !mem_ready)
            wait_next = wait_reg + 1'b1;
    end

    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 2'b00;
        RegDst     = 2'b00;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = '0;
        illegal_op = 1'b0;
        // Reset overrides every output, including FETCH's read request.
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALUOP_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = ALUOP_ADD;
                end
                S_EXE_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_R;
                end
                S_EXE_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = (OP == 6'h0c) ? ALUOP_AND :
                              (OP == 6'h08) ? ALUOP_ADD : ALUOP_OR;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = (OP == 6'h00) ? 2'b01 : 2'b00;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = ALUOP_SUB;
                    PCSource = 2'b01;
                    PCWrite  = (OP == 6'h04) ? Zero : (OP == 6'h05) ? !Zero : 1'b0;
                end
`ifdef MULTICYCLE_CTRL_JUMP_EN
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    if (OP == 6'h03) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
`endif
                S_TRAP:  illegal_op = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
